branch_sequencer: RTL and testbench

//  Sequences conditional-branch resolution (beq/bne/blt/bge/bltu/bgeu) between decode and fetch.

---
 rtl/branch_sequencer_pkg.sv | 29 ++
 rtl/branch_sequencer_if.sv | 39 +++
 rtl/branch_cond_unit.sv | 35 +++
 rtl/branch_sequencer.sv | 156 +++++++++++++++
 tb/tb_branch_sequencer.sv | 432 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/branch_sequencer_pkg.sv
// Shared definitions for the branch sequencer: funct3 encodings, FSM states and default widths.
package branch_sequencer_pkg;

  localparam int unsigned DEFAULT_XLEN  = 32;
  localparam int unsigned DEFAULT_CNT_W = 16;

  localparam logic [2:0] BR_BEQ  = 3'b000;
  localparam logic [2:0] BR_BNE  = 3'b001;
  localparam logic [2:0] BR_BLT  = 3'b100;
  localparam logic [2:0] BR_BGE  = 3'b101;
  localparam logic [2:0] BR_BLTU = 3'b110;
  localparam logic [2:0] BR_BGEU = 3'b111;

  typedef enum logic [1:0] {
    StIdle,
    StWaitOps,
    StResolve,
    StFlush
  } state_e;

  // Branch target with bit 0 cleared, wrapping at the operand width.
  function automatic logic [DEFAULT_XLEN-1:0] branch_target(input logic [DEFAULT_XLEN-1:0] pc,
                                                            input logic [DEFAULT_XLEN-1:0] imm);
    logic [DEFAULT_XLEN-1:0] sum;
    sum = pc + imm;
    return {sum[DEFAULT_XLEN-1:1], 1'b0};
  endfunction

endpackage

// File: rtl/branch_sequencer_if.sv
// Decode/fetch-facing bundle of the branch sequencer; master is the pipeline, slave the sequencer.
interface branch_sequencer_if
  import branch_sequencer_pkg::*;
#(
  parameter int unsigned XLEN  = DEFAULT_XLEN,
  parameter int unsigned CNT_W = DEFAULT_CNT_W
) ();

  logic             br_valid;
  logic             br_ready;
  logic [2:0]       br_funct3;
  logic [XLEN-1:0]  br_pc;
  logic [XLEN-1:0]  br_imm;
  logic             ops_ready;
  logic [XLEN-1:0]  rs1_data;
  logic [XLEN-1:0]  rs2_data;
  logic             kill;
  logic             redirect_valid;
  logic [XLEN-1:0]  redirect_pc;
  logic             flush;
  logic             stall_fetch;
  logic             misalign_exc;
  logic             illegal_br;
  logic [CNT_W-1:0] br_count;
  logic [CNT_W-1:0] taken_count;

  modport master (
    output br_valid, br_funct3, br_pc, br_imm, ops_ready, rs1_data, rs2_data, kill,
    input  br_ready, redirect_valid, redirect_pc, flush, stall_fetch, misalign_exc, illegal_br,
    input  br_count, taken_count
  );

  modport slave (
    input  br_valid, br_funct3, br_pc, br_imm, ops_ready, rs1_data, rs2_data, kill,
    output br_ready, redirect_valid, redirect_pc, flush, stall_fetch, misalign_exc, illegal_br,
    output br_count, taken_count
  );

endinterface

// File: rtl/branch_cond_unit.sv
// Combinational branch condition evaluator: funct3 and operands to taken/illegal.
module branch_cond_unit
  import branch_sequencer_pkg::*;
#(
  parameter int unsigned XLEN = DEFAULT_XLEN
) (
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  output logic            taken,
  output logic            illegal
);

  logic eq, lt_s, lt_u;

  assign eq   = (rs1 == rs2);
  assign lt_s = ($signed(rs1) < $signed(rs2));
  assign lt_u = (rs1 < rs2);

  always_comb begin
    taken   = 1'b0;
    illegal = 1'b0;
    case (funct3)
      BR_BEQ:  taken = eq;
      BR_BNE:  taken = !eq;
      BR_BLT:  taken = lt_s;
      BR_BGE:  taken = !lt_s;
      BR_BLTU: taken = lt_u;
      BR_BGEU: taken = !lt_u;
      // 010/011 are reserved; report and resolve as not taken
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/branch_sequencer.sv
// Branch sequencer top: accepts one branch, waits for operands, resolves, redirects and flushes.
module branch_sequencer
  import branch_sequencer_pkg::*;
#(
  parameter int unsigned XLEN         = DEFAULT_XLEN,
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter int unsigned CNT_W        = DEFAULT_CNT_W
) (
  input logic               clk,
  input logic               rst_n,
  branch_sequencer_if.slave bus
);

  localparam int unsigned FCNT_W = $clog2(FLUSH_CYCLES + 1);

  state_e            state_q, state_d;
  logic [2:0]        funct3_q;
  logic [XLEN-1:0]   pc_q, imm_q, rs1_q, rs2_q;
  logic [FCNT_W-1:0] fcnt_q, fcnt_d;
  logic [CNT_W-1:0]  br_cnt_q, taken_cnt_q;
  logic [XLEN-1:0]   redirect_pc_q, target;

  logic redirect_valid_q, redirect_valid_d;
  logic flush_q, flush_d;
  logic misalign_q, misalign_d;
  logic illegal_q, illegal_d;

  logic accept, ops_capture;
  logic cond_taken, cond_illegal;
  logic resolve_live, do_redirect, do_misalign;

  assign accept      = (state_q == StIdle) && bus.br_valid;
  assign ops_capture = bus.ops_ready && (accept || (state_q == StWaitOps));

  branch_cond_unit #(
    .XLEN(XLEN)
  ) u_cond (
    .funct3  (funct3_q),
    .rs1     (rs1_q),
    .rs2     (rs2_q),
    .taken   (cond_taken),
    .illegal (cond_illegal)
  );

  assign target       = (pc_q + imm_q) & ~XLEN'(1);
  assign resolve_live = (state_q == StResolve) && !bus.kill;
  assign do_redirect  = resolve_live && cond_taken && !target[1];
  assign do_misalign  = resolve_live && cond_taken && target[1];

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      fcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      fcnt_q  <= fcnt_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    fcnt_d  = fcnt_q;
    unique case (state_q)
      StIdle: begin
        if (bus.br_valid) state_d = bus.ops_ready ? StResolve : StWaitOps;
      end
      StWaitOps: begin
        if (bus.kill)           state_d = StIdle;
        else if (bus.ops_ready) state_d = StResolve;
      end
      StResolve: begin
        if (do_redirect) begin
          state_d = StFlush;
          fcnt_d  = FCNT_W'(FLUSH_CYCLES);
        end else begin
          state_d = StIdle;
        end
      end
      StFlush: begin
        fcnt_d = fcnt_q - FCNT_W'(1);
        if (fcnt_q == FCNT_W'(1)) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Output logic: next values of the registered pulses
  always_comb begin
    redirect_valid_d = do_redirect;
    misalign_d       = do_misalign;
    illegal_d        = resolve_live && cond_illegal;
    flush_d          = (state_d == StFlush);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= '0;
      flush_q          <= 1'b0;
      misalign_q       <= 1'b0;
      illegal_q        <= 1'b0;
    end else begin
      redirect_valid_q <= redirect_valid_d;
      flush_q          <= flush_d;
      misalign_q       <= misalign_d;
      illegal_q        <= illegal_d;
      if (do_redirect) redirect_pc_q <= target;
    end
  end

  // Capture registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      funct3_q <= '0;
      pc_q     <= '0;
      imm_q    <= '0;
      rs1_q    <= '0;
      rs2_q    <= '0;
    end else begin
      if (accept) begin
        funct3_q <= bus.br_funct3;
        pc_q     <= bus.br_pc;
        imm_q    <= bus.br_imm;
      end
      if (ops_capture) begin
        rs1_q <= bus.rs1_data;
        rs2_q <= bus.rs2_data;
      end
    end
  end

  // Saturating performance counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      br_cnt_q    <= '0;
      taken_cnt_q <= '0;
    end else begin
      if (resolve_live && !(&br_cnt_q))   br_cnt_q    <= br_cnt_q + CNT_W'(1);
      if (do_redirect && !(&taken_cnt_q)) taken_cnt_q <= taken_cnt_q + CNT_W'(1);
    end
  end

  // br_ready is gated by reset so every output reads 0 while rst_n is low
  assign bus.br_ready       = rst_n && (state_q == StIdle);
  assign bus.stall_fetch    = (state_q != StIdle);
  assign bus.redirect_valid = redirect_valid_q;
  assign bus.redirect_pc    = redirect_pc_q;
  assign bus.flush          = flush_q;
  assign bus.misalign_exc   = misalign_q;
  assign bus.illegal_br     = illegal_q;
  assign bus.br_count       = br_cnt_q;
  assign bus.taken_count    = taken_cnt_q;

endmodule

// File: tb/tb_branch_sequencer.sv
// Directed-vector bench for branch_sequencer; a second small instance covers counter saturation.
module tb_branch_sequencer;
  import branch_sequencer_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  branch_sequencer_if #(.XLEN(32), .CNT_W(16)) bus ();
  branch_sequencer_if #(.XLEN(32), .CNT_W(3))  bus_s ();

  branch_sequencer #(.XLEN(32), .FLUSH_CYCLES(2), .CNT_W(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  branch_sequencer #(.XLEN(32), .FLUSH_CYCLES(1), .CNT_W(3)) dut_s (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_s)
  );

  assign bus_s.br_valid  = bus.br_valid;
  assign bus_s.br_funct3 = bus.br_funct3;
  assign bus_s.br_pc     = bus.br_pc;
  assign bus_s.br_imm    = bus.br_imm;
  assign bus_s.ops_ready = bus.ops_ready;
  assign bus_s.rs1_data  = bus.rs1_data;
  assign bus_s.rs2_data  = bus.rs2_data;
  assign bus_s.kill      = bus.kill;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.br_valid  = 1'b0;
    bus.br_funct3 = 3'b000;
    bus.br_pc     = '0;
    bus.br_imm    = '0;
    bus.ops_ready = 1'b0;
    bus.rs1_data  = '0;
    bus.rs2_data  = '0;
    bus.kill      = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clear_inputs();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  // Presents one branch for a single accepting edge; returns #1 after that edge.
  task automatic issue(input logic [2:0] f3, input logic [31:0] pc, input logic [31:0] imm,
                       input logic [31:0] a, input logic [31:0] b, input logic ops);
    bus.br_valid  = 1'b1;
    bus.br_funct3 = f3;
    bus.br_pc     = pc;
    bus.br_imm    = imm;
    bus.ops_ready = ops;
    bus.rs1_data  = a;
    bus.rs2_data  = b;
    tick();
    bus.br_valid  = 1'b0;
    bus.ops_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    clear_inputs();
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if ({bus.redirect_valid, bus.flush, bus.stall_fetch, bus.misalign_exc, bus.illegal_br,
         bus.br_ready} !== 6'b0) begin
      miscompares++;
      $display("FAIL reset_flags: got %b want 000000", {bus.redirect_valid, bus.flush,
               bus.stall_fetch, bus.misalign_exc, bus.illegal_br, bus.br_ready});
    end
    vectors++;
    if ({bus.br_count, bus.taken_count, bus.redirect_pc} !== 64'd0) begin
      miscompares++;
      $display("FAIL reset_values: br=%0d taken=%0d pc=%h want 0", bus.br_count,
               bus.taken_count, bus.redirect_pc);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    vectors++;
    if (bus.br_ready !== 1'b1 || bus.stall_fetch !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_idle: ready=%b stall=%b want 1/0", bus.br_ready, bus.stall_fetch);
    end
  endtask

  task automatic test_beq_taken();
    do_reset();
    issue(BR_BEQ, 32'h100, 32'h20, 32'd5, 32'd5, 1'b1);
    vectors++;
    if (bus.stall_fetch !== 1'b1 || bus.br_ready !== 1'b0 || bus.redirect_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL beq_resolve_cycle: stall=%b ready=%b redir=%b want 1/0/0",
               bus.stall_fetch, bus.br_ready, bus.redirect_valid);
    end
    tick();
    vectors++;
    if (bus.redirect_valid !== 1'b1 || bus.redirect_pc !== 32'h120 || bus.flush !== 1'b1) begin
      miscompares++;
      $display("FAIL beq_redirect: valid=%b pc=%h flush=%b want 1/120/1", bus.redirect_valid,
               bus.redirect_pc, bus.flush);
    end
    tick();
    vectors++;
    if (bus.redirect_valid !== 1'b0 || bus.flush !== 1'b1 || bus.stall_fetch !== 1'b1) begin
      miscompares++;
      $display("FAIL beq_flush2: valid=%b flush=%b stall=%b want 0/1/1", bus.redirect_valid,
               bus.flush, bus.stall_fetch);
    end
    tick();
    vectors++;
    if (bus.flush !== 1'b0 || bus.stall_fetch !== 1'b0 || bus.br_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL beq_flush_end: flush=%b stall=%b ready=%b want 0/0/1", bus.flush,
               bus.stall_fetch, bus.br_ready);
    end
    vectors++;
    if (bus.br_count !== 16'd1 || bus.taken_count !== 16'd1) begin
      miscompares++;
      $display("FAIL beq_counts: br=%0d taken=%0d want 1/1", bus.br_count, bus.taken_count);
    end
  endtask

  task automatic test_bne_not_taken();
    do_reset();
    issue(BR_BNE, 32'h100, 32'h20, 32'd7, 32'd7, 1'b1);
    tick();
    vectors++;
    if (bus.redirect_valid !== 1'b0 || bus.flush !== 1'b0 || bus.stall_fetch !== 1'b0) begin
      miscompares++;
      $display("FAIL bne_outputs: redir=%b flush=%b stall=%b want 0/0/0", bus.redirect_valid,
               bus.flush, bus.stall_fetch);
    end
    vectors++;
    if (bus.br_count !== 16'd1 || bus.taken_count !== 16'd0) begin
      miscompares++;
      $display("FAIL bne_counts: br=%0d taken=%0d want 1/0", bus.br_count, bus.taken_count);
    end
  endtask

  task automatic test_signed_unsigned();
    do_reset();
    // blt -1 < 1 signed: taken; imm odd checks bit0 clearing (0x211 -> 0x210)
    issue(BR_BLT, 32'h200, 32'h11, 32'hFFFF_FFFF, 32'd1, 1'b1);
    tick();
    vectors++;
    if (bus.redirect_valid !== 1'b1 || bus.redirect_pc !== 32'h210) begin
      miscompares++;
      $display("FAIL blt_taken: valid=%b pc=%h want 1/210", bus.redirect_valid, bus.redirect_pc);
    end
    tick();
    tick();
    issue(BR_BLTU, 32'h200, 32'h40, 32'hFFFF_FFFF, 32'd1, 1'b1);
    tick();
    vectors++;
    if (bus.redirect_valid !== 1'b0 || bus.flush !== 1'b0) begin
      miscompares++;
      $display("FAIL bltu_not_taken: valid=%b flush=%b want 0/0", bus.redirect_valid, bus.flush);
    end
    issue(BR_BGE, 32'h200, 32'h40, 32'hFFFF_FFFF, 32'd1, 1'b1);
    tick();
    vectors++;
    if (bus.redirect_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL bge_not_taken: valid=%b want 0", bus.redirect_valid);
    end
    // bgeu taken with negative offset: 0x300 - 16 = 0x2F0
    issue(BR_BGEU, 32'h300, 32'hFFFF_FFF0, 32'hFFFF_FFFF, 32'd1, 1'b1);
    tick();
    vectors++;
    if (bus.redirect_valid !== 1'b1 || bus.redirect_pc !== 32'h2F0) begin
      miscompares++;
      $display("FAIL bgeu_taken: valid=%b pc=%h want 1/2f0", bus.redirect_valid, bus.redirect_pc);
    end
    tick();
    tick();
    vectors++;
    if (bus.br_count !== 16'd4 || bus.taken_count !== 16'd2) begin
      miscompares++;
      $display("FAIL cmp_counts: br=%0d taken=%0d want 4/2", bus.br_count, bus.taken_count);
    end
  endtask

  task automatic test_wait_ops();
    do_reset();
    // rs2=4 at accept would be not taken; the value present with ops_ready (3) must be used
    issue(BR_BEQ, 32'h40, 32'h8, 32'd3, 32'd4, 1'b0);
    vectors++;
    if (bus.stall_fetch !== 1'b1 || bus.br_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL wait_stall: stall=%b ready=%b want 1/0", bus.stall_fetch, bus.br_ready);
    end
    bus.br_valid = 1'b1;
    bus.br_pc    = 32'h500;
    bus.br_imm   = 32'h0;
    tick();
    bus.br_valid = 1'b0;
    tick();
    vectors++;
    if (bus.stall_fetch !== 1'b1 || bus.redirect_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL wait_hold: stall=%b redir=%b want 1/0", bus.stall_fetch, bus.redirect_valid);
    end
    bus.ops_ready = 1'b1;
    bus.rs2_data  = 32'd3;
    tick();
    bus.ops_ready = 1'b0;
    vectors++;
    if (bus.redirect_valid !== 1'b0 || bus.stall_fetch !== 1'b1) begin
      miscompares++;
      $display("FAIL wait_resolve: redir=%b stall=%b want 0/1", bus.redirect_valid,
               bus.stall_fetch);
    end
    tick();
    vectors++;
    if (bus.redirect_valid !== 1'b1 || bus.redirect_pc !== 32'h48) begin
      miscompares++;
      $display("FAIL wait_redirect: valid=%b pc=%h want 1/48", bus.redirect_valid,
               bus.redirect_pc);
    end
    tick();
    tick();
  endtask

  task automatic test_kill();
    do_reset();
    issue(BR_BEQ, 32'h100, 32'h20, 32'd5, 32'd5, 1'b1);
    bus.kill = 1'b1;
    tick();
    bus.kill = 1'b0;
    vectors++;
    if (bus.redirect_valid !== 1'b0 || bus.flush !== 1'b0 || bus.stall_fetch !== 1'b0) begin
      miscompares++;
      $display("FAIL kill_resolve: redir=%b flush=%b stall=%b want 0/0/0", bus.redirect_valid,
               bus.flush, bus.stall_fetch);
    end
    vectors++;
    if (bus.br_count !== 16'd0 || bus.taken_count !== 16'd0) begin
      miscompares++;
      $display("FAIL kill_counts: br=%0d taken=%0d want 0/0", bus.br_count, bus.taken_count);
    end
    issue(BR_BEQ, 32'h100, 32'h20, 32'd5, 32'd5, 1'b0);
    bus.kill = 1'b1;
    tick();
    bus.kill = 1'b0;
    vectors++;
    if (bus.stall_fetch !== 1'b0 || bus.br_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL kill_wait: stall=%b ready=%b want 0/1", bus.stall_fetch, bus.br_ready);
    end
    // Kill during flush is ignored
    issue(BR_BEQ, 32'h100, 32'h20, 32'd5, 32'd5, 1'b1);
    tick();
    bus.kill = 1'b1;
    tick();
    bus.kill = 1'b0;
    vectors++;
    if (bus.flush !== 1'b1 || bus.taken_count !== 16'd1) begin
      miscompares++;
      $display("FAIL kill_flush: flush=%b taken=%0d want 1/1", bus.flush, bus.taken_count);
    end
    tick();
  endtask

  task automatic test_illegal();
    do_reset();
    issue(3'b010, 32'h100, 32'h20, 32'd1, 32'd1, 1'b1);
    tick();
    vectors++;
    if (bus.illegal_br !== 1'b1 || bus.redirect_valid !== 1'b0 || bus.br_count !== 16'd1) begin
      miscompares++;
      $display("FAIL illegal_010: ill=%b redir=%b br=%0d want 1/0/1", bus.illegal_br,
               bus.redirect_valid, bus.br_count);
    end
    issue(3'b011, 32'h100, 32'h20, 32'd1, 32'd2, 1'b1);
    vectors++;
    if (bus.illegal_br !== 1'b0) begin
      miscompares++;
      $display("FAIL illegal_pulse_width: ill=%b want 0", bus.illegal_br);
    end
    tick();
    vectors++;
    if (bus.illegal_br !== 1'b1 || bus.taken_count !== 16'd0) begin
      miscompares++;
      $display("FAIL illegal_011: ill=%b taken=%0d want 1/0", bus.illegal_br, bus.taken_count);
    end
  endtask

  task automatic test_misalign();
    do_reset();
    issue(BR_BEQ, 32'h100, 32'h2, 32'd5, 32'd5, 1'b1);
    tick();
    vectors++;
    if (bus.misalign_exc !== 1'b1 || bus.redirect_valid !== 1'b0 || bus.flush !== 1'b0 ||
        bus.stall_fetch !== 1'b0) begin
      miscompares++;
      $display("FAIL misalign: exc=%b redir=%b flush=%b stall=%b want 1/0/0/0",
               bus.misalign_exc, bus.redirect_valid, bus.flush, bus.stall_fetch);
    end
    vectors++;
    if (bus.br_count !== 16'd1 || bus.taken_count !== 16'd0) begin
      miscompares++;
      $display("FAIL misalign_counts: br=%0d taken=%0d want 1/0", bus.br_count, bus.taken_count);
    end
    tick();
    vectors++;
    if (bus.misalign_exc !== 1'b0) begin
      miscompares++;
      $display("FAIL misalign_pulse: exc=%b want 0", bus.misalign_exc);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    issue(BR_BNE, 32'h10, 32'h8, 32'd1, 32'd1, 1'b1);
    tick();
    vectors++;
    if (bus.br_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL b2b_ready: ready=%b want 1", bus.br_ready);
    end
    issue(BR_BNE, 32'h10, 32'h8, 32'd1, 32'd2, 1'b1);
    tick();
    vectors++;
    if (bus.redirect_valid !== 1'b1 || bus.redirect_pc !== 32'h18 || bus.br_count !== 16'd2) begin
      miscompares++;
      $display("FAIL b2b_second: valid=%b pc=%h br=%0d want 1/18/2", bus.redirect_valid,
               bus.redirect_pc, bus.br_count);
    end
    tick();
    tick();
  endtask

  task automatic test_saturation();
    do_reset();
    for (int i = 0; i < 9; i++) begin
      issue(BR_BEQ, 32'h1000, 32'h40, 32'd9, 32'd9, 1'b1);
      tick();
      if (i == 0) begin
        vectors++;
        if (bus_s.flush !== 1'b1) begin
          miscompares++;
          $display("FAIL small_flush_on: flush=%b want 1", bus_s.flush);
        end
      end
      tick();
      if (i == 0) begin
        vectors++;
        if (bus_s.flush !== 1'b0 || bus.flush !== 1'b1) begin
          miscompares++;
          $display("FAIL small_flush_len: small=%b main=%b want 0/1", bus_s.flush, bus.flush);
        end
      end
      tick();
    end
    vectors++;
    if (bus.br_count !== 16'd9 || bus.taken_count !== 16'd9) begin
      miscompares++;
      $display("FAIL sat_main: br=%0d taken=%0d want 9/9", bus.br_count, bus.taken_count);
    end
    vectors++;
    if (bus_s.br_count !== 3'd7 || bus_s.taken_count !== 3'd7) begin
      miscompares++;
      $display("FAIL sat_small: br=%0d taken=%0d want 7/7", bus_s.br_count, bus_s.taken_count);
    end
  endtask

  task automatic test_reset_in_flush();
    do_reset();
    issue(BR_BEQ, 32'h100, 32'h20, 32'd5, 32'd5, 1'b1);
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({bus.redirect_valid, bus.flush, bus.stall_fetch, bus.br_ready} !== 4'b0 ||
        {bus.br_count, bus.taken_count, bus.redirect_pc} !== 64'd0) begin
      miscompares++;
      $display("FAIL rst_in_flush: redir=%b flush=%b stall=%b ready=%b br=%0d taken=%0d pc=%h",
               bus.redirect_valid, bus.flush, bus.stall_fetch, bus.br_ready, bus.br_count,
               bus.taken_count, bus.redirect_pc);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    vectors++;
    if (bus.br_ready !== 1'b1 || bus.flush !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_recover: ready=%b flush=%b want 1/0", bus.br_ready, bus.flush);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_beq_taken();
    test_bne_not_taken();
    test_signed_unsigned();
    test_wait_ops();
    test_kill();
    test_illegal();
    test_misalign();
    test_back_to_back();
    test_saturation();
    test_reset_in_flush();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
